// File: rtl/nco_pkg.sv
// Purpose: shared widths, FSM state type and the quarter-wave fold helper for the NCO/sine path.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package nco_pkg;

    localparam int NCO_PHASE_W = 24;
    localparam int NCO_ADDR_W  = 7;
    localparam int NCO_DIV_W   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Returns {invert, addr}: quadrant bit 1 selects the negative half-wave,
    // quadrant bit 0 mirrors the address so the ROM only stores 0..pi/2.
    function automatic logic [NCO_ADDR_W:0] fold_addr(input logic [NCO_PHASE_W-1:0] phase);
        logic [1:0]            q;
        logic [NCO_ADDR_W-1:0] a;
        q = phase[NCO_PHASE_W-1 -: 2];
        a = phase[NCO_PHASE_W-3 -: NCO_ADDR_W];
        return {q[1], (q[0] ? ~a : a)};
    endfunction

endpackage

// File: rtl/nco_phase_gen_sample_div.sv
// Purpose: sample-rate divider, one tick every sample_div+1 cycles while enabled.
// Latency: tick is combinational from the registered count; clear restarts the count next cycle.
// Backpressure: none; clear suppresses the tick of the cycle it is asserted in.
module nco_sample_div
    import nco_pkg::*;
#(
    parameter int DIV_W = NCO_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic [DIV_W-1:0] sample_div,
    output logic             tick
);

    logic [DIV_W-1:0] div_cnt;

    assign tick = en && !clear && (div_cnt == sample_div);

    // Count 0..sample_div while enabled; held at 0 when disabled or cleared.
    // The >= return also recovers cleanly if sample_div is lowered below the count.
    always_ff @(posedge clk) begin
        if (rst || !en || clear) begin
            div_cnt <= '0;
        end else if (div_cnt >= sample_div) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nco_phase_gen.sv
// Purpose: phase accumulator with wrap-aligned FTW updates, folded to a quarter-wave ROM address.
// Latency: tick to rom_addr 2 cycles; tick to data_invert/data_valid 2+ROM_LAT cycles.
// Backpressure: ftw_ready low while a tuning word is pending; ROM-side outputs are not throttled.
module nco_phase_gen
    import nco_pkg::*;
#(
    parameter int PHASE_W = NCO_PHASE_W,
    parameter int ADDR_W  = NCO_ADDR_W,
    parameter int DIV_W   = NCO_DIV_W,
    parameter int ROM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               phase_clear,
    input  logic [DIV_W-1:0]   sample_div,
    input  logic [PHASE_W-1:0] ftw_data,
    input  logic               ftw_valid,
    output logic               ftw_ready,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               addr_valid,
    output logic               data_invert,
    output logic               data_valid,
    output logic               wrap
);

    state_t               state;
    state_t               state_nxt;
    logic                 div_en;
    logic                 is_idle;
    logic                 tick;
    logic [PHASE_W-1:0]   phase;
    logic [PHASE_W-1:0]   ftw_active;
    logic [PHASE_W-1:0]   ftw_pending;
    logic                 pend_flag;
    logic [PHASE_W:0]     sum;
    logic                 carry;
    logic                 apply;
    logic                 accept;
    logic                 upd;
    logic [ADDR_W:0]      fold;
    logic                 inv_s1;
    logic [ROM_LAT-1:0]   inv_sr;
    logic [ROM_LAT-1:0]   vld_sr;

    // State register simply tracks run one cycle behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded controls.
    always_comb begin
        state_nxt = IDLE;
        div_en    = 1'b0;
        is_idle   = 1'b1;
        if (run) begin
            state_nxt = RUN;
        end
        if (state == RUN) begin
            div_en  = 1'b1;
            is_idle = 1'b0;
        end
    end

    nco_sample_div #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .en         (div_en),
        .clear      (phase_clear),
        .sample_div (sample_div),
        .tick       (tick)
    );

    assign sum       = {1'b0, phase} + {1'b0, ftw_active};
    assign carry     = tick && sum[PHASE_W];
    assign ftw_ready = !pend_flag && !rst;
    assign accept    = ftw_valid && ftw_ready;
    // A pending word only takes effect where it cannot tear a period.
    assign apply     = pend_flag && (phase_clear || is_idle || carry);
    assign fold      = fold_addr(phase);

    // Phase accumulator, wrap pulse and the FTW pending/active pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= '0;
            ftw_active  <= '0;
            ftw_pending <= '0;
            pend_flag   <= 1'b0;
            wrap        <= 1'b0;
            upd         <= 1'b0;
        end else begin
            if (phase_clear) begin
                phase <= '0;
            end else if (tick) begin
                phase <= sum[PHASE_W-1:0];
            end
            wrap <= carry;
            upd  <= tick || phase_clear;
            if (apply) begin
                ftw_active <= ftw_pending;
                pend_flag  <= 1'b0;
            end else if (accept) begin
                ftw_pending <= ftw_data;
                pend_flag   <= 1'b1;
            end
        end
    end

    // Fold the freshly updated phase into the quarter-wave address.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr   <= '0;
            inv_s1     <= 1'b0;
            addr_valid <= 1'b0;
        end else begin
            addr_valid <= upd;
            if (upd) begin
                rom_addr <= fold[ADDR_W-1:0];
                inv_s1   <= fold[ADDR_W];
            end
        end
    end

    // Delay invert/valid by the ROM read latency so they meet the read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_sr <= '0;
            vld_sr <= '0;
        end else begin
            inv_sr[0] <= inv_s1;
            vld_sr[0] <= addr_valid;
            for (int i = 1; i < ROM_LAT; i++) begin
                inv_sr[i] <= inv_sr[i-1];
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    assign data_invert = inv_sr[ROM_LAT-1];
    assign data_valid  = vld_sr[ROM_LAT-1];

endmodule

// File: tb/tb_nco_phase_gen.sv
// Purpose: randomized and directed stimulus for nco_phase_gen against a cycle-level arithmetic model.
// Latency: expected addresses/flags queued at issue, popped by the monitor when the DUT shows them.
// Backpressure: ftw_valid is held until the model sees the handshake complete.
module tb_nco_phase_gen;

    localparam int PW = 24;
    localparam int AW = 7;
    localparam int DW = 16;
    localparam int RL = 1;
    localparam longint MODP = 64'd1 << PW;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          phase_clear;
    logic [DW-1:0] sample_div;
    logic [PW-1:0] ftw_data;
    logic          ftw_valid;
    logic          ftw_ready;
    logic [AW-1:0] rom_addr;
    logic          addr_valid;
    logic          data_invert;
    logic          data_valid;
    logic          wrap;

    always #5 clk = ~clk;

    nco_phase_gen #(
        .PHASE_W (PW),
        .ADDR_W  (AW),
        .DIV_W   (DW),
        .ROM_LAT (RL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .phase_clear (phase_clear),
        .sample_div  (sample_div),
        .ftw_data    (ftw_data),
        .ftw_valid   (ftw_valid),
        .ftw_ready   (ftw_ready),
        .rom_addr    (rom_addr),
        .addr_valid  (addr_valid),
        .data_invert (data_invert),
        .data_valid  (data_valid),
        .wrap        (wrap)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: the phase as a plain integer modulo 2^PW.
    longint m_phase   = 0;
    longint m_active  = 0;
    longint m_pending = 0;
    bit     m_pflag   = 1'b0;
    bit     m_run_q   = 1'b0;
    int     m_div     = 0;

    int exp_addr[$];
    bit exp_inv[$];
    int av_cyc[$];
    int exp_wrap[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Expected ROM-side view of a phase: quadrant and mirrored quarter-wave index.
    function automatic void push_update(input longint p);
        longint q;
        longint a;
        q = p >> (PW - 2);
        a = (p >> (PW - 2 - AW)) % (64'd1 << AW);
        exp_addr.push_back(int'((q % 2 == 1) ? ((64'd1 << AW) - 1 - a) : a));
        exp_inv.push_back(q >= 2);
    endfunction

    // Advance model and DUT by one clock with the currently driven inputs.
    task automatic step();
        bit     tick;
        bit     carry;
        bit     apply;
        bit     accept;
        longint sum;
        @(negedge clk);
        #1;
        if (rst) begin
            m_phase = 0; m_active = 0; m_pending = 0;
            m_pflag = 0; m_run_q = 0; m_div = 0;
            exp_addr.delete(); exp_inv.delete(); av_cyc.delete(); exp_wrap.delete();
        end else begin
            tick   = m_run_q && !phase_clear && (m_div == int'(sample_div));
            sum    = m_phase + m_active;
            carry  = tick && (sum >= MODP);
            apply  = m_pflag && (phase_clear || !m_run_q || carry);
            accept = ftw_valid && !m_pflag;
            if (!m_run_q || phase_clear || m_div == int'(sample_div)) m_div = 0;
            else m_div++;
            if (phase_clear) begin
                m_phase = 0;
                push_update(0);
            end else if (tick) begin
                m_phase = sum % MODP;
                push_update(m_phase);
            end
            if (carry) exp_wrap.push_back(cyc + 1);
            if (apply) begin
                m_active = m_pending;
                m_pflag  = 0;
            end else if (accept) begin
                m_pending = longint'(ftw_data);
                m_pflag   = 1;
            end
            m_run_q = run;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_ftw(input logic [PW-1:0] w, input int limit);
        bit done;
        bit was_free;
        done      = 0;
        ftw_valid = 1'b1;
        ftw_data  = w;
        for (int i = 0; i < limit && !done; i++) begin
            was_free = !m_pflag;
            step();
            if (was_free) done = 1;
        end
        ftw_valid = 1'b0;
        if (!done) flag_fail("ftw_accept_timeout");
    endtask

    task automatic run_until(input longint target, input int limit);
        bit hit;
        hit = (m_phase == target);
        for (int i = 0; i < limit && !hit; i++) begin
            step();
            hit = (m_phase == target);
        end
        if (!hit) flag_fail("phase_target_timeout");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        phase_clear = 1'b0;
        ftw_valid = 1'b0;
        step();
        check("rst_rom_addr", rom_addr, 0);
        check("rst_addr_valid", addr_valid, 0);
        check("rst_data_invert", data_invert, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_wrap", wrap, 0);
        check("rst_ftw_ready", ftw_ready, 0);
        step();
        rst = 1'b0;
        step();
    endtask

    // Monitor: pops expectations whenever the DUT presents something.
    always @(negedge clk) begin
        if (addr_valid === 1'b1) begin
            if (exp_addr.size() == 0) flag_fail("addr_valid_unexpected");
            else check("rom_addr", rom_addr, exp_addr.pop_front());
            av_cyc.push_back(cyc);
        end
        if (data_valid === 1'b1) begin
            if (exp_inv.size() == 0) flag_fail("data_valid_unexpected");
            else check("data_invert", data_invert, exp_inv.pop_front());
            if (av_cyc.size() == 0) flag_fail("data_valid_without_addr");
            else check("rom_lat_align", cyc - av_cyc.pop_front(), RL);
        end
        if (wrap === 1'b1) begin
            if (exp_wrap.size() == 0) flag_fail("wrap_unexpected");
            else check("wrap_cycle", cyc, exp_wrap.pop_front());
        end
        check("ftw_ready", ftw_ready, !m_pflag && !rst);
    end

    initial begin
        rst = 1'b1; run = 1'b0; phase_clear = 1'b0;
        sample_div = '0; ftw_valid = 1'b0; ftw_data = '0;
        step();
        do_reset();

        // Full period at one tick per cycle, FTW loaded while idle.
        send_ftw(24'h008000, 4);
        run = 1'b1;
        steps(2048 + 8);

        // Divided sample rate.
        do_reset();
        sample_div = 16'd3;
        send_ftw(24'h008000, 4);
        run = 1'b1;
        steps(2048 * 4 + 8);

        // Mid-period FTW change waits for the wrap; second word queued behind it.
        do_reset();
        sample_div = '0;
        send_ftw(24'h008000, 4);
        run = 1'b1;
        run_until(64'h400000, 400);
        send_ftw(24'h010000, 4);
        send_ftw(24'h020000, 2000);
        steps(600);

        // phase_clear colliding with a tick, pending word applied by the clear.
        do_reset();
        send_ftw(24'h008000, 4);
        run = 1'b1;
        run_until(64'h900000, 600);
        send_ftw(24'h018000, 4);
        run_until(64'h9A0000, 100);
        phase_clear = 1'b1;
        step();
        phase_clear = 1'b0;
        steps(300);

        // Drop run so the phase settles at 0x3F8000, then retune while idle.
        do_reset();
        send_ftw(24'h008000, 4);
        run = 1'b1;
        run_until(64'h3F0000, 400);
        run = 1'b0;
        step();
        send_ftw(24'h004000, 4);
        steps(5);
        run = 1'b1;
        steps(300);

        // Reset while a word is pending: it must be discarded.
        do_reset();
        send_ftw(24'h008000, 4);
        run = 1'b1;
        steps(50);
        send_ftw(24'h070000, 4);
        steps(3);
        do_reset();
        send_ftw(24'h00C000, 4);
        run = 1'b1;
        steps(200);

        // Randomized mix of run, clears, retunes, divider changes and resets.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) run = ~run;
            phase_clear = ($urandom_range(0, 63) == 0);
            if (m_div == 0 && $urandom_range(0, 15) == 0) sample_div = DW'($urandom_range(0, 3));
            ftw_valid = ($urandom_range(0, 7) == 0);
            ftw_data  = PW'($urandom_range(0, 24'h0FFFFF));
            rst       = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0; run = 1'b0; phase_clear = 1'b0; ftw_valid = 1'b0;
        steps(8);

        check("leftover_addr", exp_addr.size(), 0);
        check("leftover_inv", exp_inv.size(), 0);
        check("leftover_wrap", exp_wrap.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
